bpm_estimator: RTL and testbench
================================

Name: bpm_estimator

Overview:
- Producer of the BPM estimate consumed by the pixel-wise filters.
- Measures the interval between beat strobes from the audio onset detector, converts the interval to beats-per-minute with a sequential divider, smooths it over a 4-entry moving average, and drives a stable, clamped BPM word.
- Also provides valid and update strobes for the video filter chain.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency; TICKS_PER_MS = CLK_FREQ_HZ/1000 (must be ≥1).
- MIN_BPM, 40, slowest accepted tempo; MAX_INTERVAL_MS = 60000/MIN_BPM = 1500.
- MAX_BPM, 200, fastest accepted tempo; MIN_INTERVAL_MS = 60000/MAX_BPM = 300.
- TIMEOUT_MS, 3000, silence duration after which the estimate is invalidated.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- beat_in, input, 1, beat indication from the onset detector; level or pulse, rising edge used.
- BPM_estimate, output, $clog2(MAX_BPM+1), smoothed BPM (8 bits at default).
- bpm_valid, output, 1, high when BPM_estimate holds a measured value.
- bpm_update, output, 1, one-cycle strobe when BPM_estimate changes due to a new measurement.

Behaviour:
- Reset (synchronous, clk rising edge, reset=1):
  - BPM_estimate=0, bpm_valid=0, bpm_update=0.
  - History cleared, beat_d=0, prescaler=0, ms_count=0, state=IDLE.
- Edge detect: edge = beat_in & ~beat_d; beat_d is the registered beat_in.
- Millisecond counter:
  - On an accepted or restarting edge: prescaler←0, ms_count←0.
  - Otherwise, if prescaler==TICKS_PER_MS-1: prescaler←0 and ms_count++ (saturating at TIMEOUT_MS); else prescaler++.
  - Beats N cycles apart therefore give ms_count = floor((N-1)/TICKS_PER_MS).
  - The counter runs in MEASURE, DIVIDE and UPDATE.
- IDLE state: on edge → MEASURE, counter cleared.
- MEASURE state, on edge:
  - ms_count < MIN_INTERVAL_MS: glitch; ignored, counter NOT cleared.
  - ms_count > MAX_INTERVAL_MS: interval discarded, counter cleared, no update; that beat becomes the new reference.
  - Otherwise: interval←ms_count, counter cleared, load divider (dividend 60000, divisor interval) → DIVIDE.
- MEASURE timeout: if ms_count reaches TIMEOUT_MS → BPM_estimate←0, bpm_valid←0, history cleared → IDLE. No bpm_update pulse on timeout.
- DIVIDE state:
  - Restoring divider, 16 cycles, one quotient bit per cycle, truncating.
  - The quotient is guaranteed in [MIN_BPM,MAX_BPM]; it is still clamped to that range.
  - Edges during DIVIDE/UPDATE are ignored; the interval since the last accepted beat is < MIN_INTERVAL_MS by construction.
  - After 16 cycles → UPDATE.
- UPDATE state (1 cycle):
  - If history is empty, all 4 entries ←q; else shift in q, dropping the oldest.
  - Register BPM_estimate ← (sum of the 4 entries)>>2, i.e. floor; the sum is 10 bits wide.
  - Set bpm_valid=1, pulse bpm_update=1 for exactly one cycle → MEASURE.
- Latency: accepted edge at clock k → BPM_estimate/bpm_update change at clock k+17.
- Output stability: BPM_estimate changes only on update, timeout or reset.
- Reset mid-DIVIDE: the result is abandoned and no update strobe is issued.

Test Plan:
- CLK_FREQ_HZ=1000, beats every 500 cycles, first two beats → bpm_update 17 cycles after the 2nd beat, BPM_estimate=120, bpm_valid=1.
- Continue with one further interval of 400 cycles → q=150, BPM_estimate=floor((120·3+150)/4)=127; a 3rd such interval → 135.
- Glitch: beat 100 cycles after an accepted beat, next beat at 500 cycles → glitch ignored, BPM_estimate stays 120, no extra bpm_update.
- Out of range: beats 2000 cycles apart → no bpm_update; a following interval of 500 → update with 120.
- Timeout: estimate 120 valid, then no beat for 3000 cycles → BPM_estimate=0, bpm_valid=0, no bpm_update; next beat pair of 500 → history refilled, 120.
- Reset asserted during DIVIDE → all outputs 0 next cycle, no bpm_update. beat_in held high for 50 cycles counts as one edge.

Source files
------------

// File: rtl/bpm_estimator.sv
// -----------------------------------------------------------------------------
// bpm_estimator
//   Produces the smoothed tempo estimate used by the pixel-wise video filters.
//   The interval between rising edges of beat_in is measured in milliseconds.
//   Each accepted interval is turned into beats-per-minute by a 16-cycle
//   restoring divider (60000 / interval), clamped to [MIN_BPM, MAX_BPM], and
//   averaged over the last four measurements.
//
// Ports
//   clk          : system clock
//   reset        : synchronous active-high reset
//   beat_in      : beat indication from the onset detector (rising edge used)
//   BPM_estimate : smoothed BPM, floor of the 4-entry mean
//   bpm_valid    : BPM_estimate holds a measured value
//   bpm_update   : one-cycle strobe when BPM_estimate takes a new measurement
// -----------------------------------------------------------------------------
module bpm_estimator #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int MIN_BPM     = 40,
  parameter int MAX_BPM     = 200,
  parameter int TIMEOUT_MS  = 3000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         beat_in,
  output logic [$clog2(MAX_BPM+1)-1:0] BPM_estimate,
  output logic                         bpm_valid,
  output logic                         bpm_update
);

  localparam int TICKS_PER_MS    = CLK_FREQ_HZ / 1000;
  localparam int MAX_INTERVAL_MS = 60000 / MIN_BPM;
  localparam int MIN_INTERVAL_MS = 60000 / MAX_BPM;
  localparam int BW  = $clog2(MAX_BPM + 1);
  localparam int SW  = BW + 2;
  localparam int MSW = $clog2(TIMEOUT_MS + 1);
  localparam int PSW = $clog2(TICKS_PER_MS + 1);

  localparam logic [MSW-1:0] MIN_INT  = MSW'(MIN_INTERVAL_MS);
  localparam logic [MSW-1:0] MAX_INT  = MSW'(MAX_INTERVAL_MS);
  localparam logic [MSW-1:0] TO_MS    = MSW'(TIMEOUT_MS);
  localparam logic [PSW-1:0] PRE_LAST = PSW'(TICKS_PER_MS - 1);
  localparam logic [15:0]    DIVIDEND = 16'd60000;

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, UPDATE} state_t;

  state_t          state_q, state_d;
  logic            beatPrev_q;
  logic [PSW-1:0]  prescaler_q, prescaler_d;
  logic [MSW-1:0]  msCount_q, msCount_d;
  logic [15:0]     rem_q, rem_d;
  logic [15:0]     quo_q, quo_d;
  logic [15:0]     divisor_q, divisor_d;
  logic [3:0]      bitCnt_q, bitCnt_d;
  logic [BW-1:0]   hist_q [4];
  logic [BW-1:0]   hist_d [4];
  logic            histValid_q, histValid_d;
  logic [BW-1:0]   bpm_q, bpm_d;
  logic            valid_q, valid_d;
  logic            update_q, update_d;

  logic            beatEdge;
  logic [PSW-1:0]  tickPre;
  logic [MSW-1:0]  tickMs;
  logic [16:0]     remShift;
  logic [15:0]     stepRem, stepQuo;
  logic [BW-1:0]   clampQ;
  logic [BW-1:0]   newHist [4];
  logic [SW-1:0]   histSum;

  assign beatEdge = beat_in & ~beatPrev_q;

  // Free-running millisecond counter advance; ms_count saturates so a long
  // silence cannot wrap back into the accepted interval range.
  always_comb begin
    tickPre = prescaler_q + 1'b1;
    tickMs  = msCount_q;
    if (prescaler_q == PRE_LAST) begin
      tickPre = '0;
      if (msCount_q != TO_MS) tickMs = msCount_q + 1'b1;
    end
  end

  // One restoring-division step: shift in the next dividend bit and subtract
  // the divisor when it fits. The dividend is shifted out of quo as the
  // quotient bits are shifted in.
  always_comb begin
    remShift = {rem_q, quo_q[15]};
    stepRem  = remShift[15:0];
    stepQuo  = {quo_q[14:0], 1'b0};
    if (remShift >= {1'b0, divisor_q}) begin
      stepRem = 16'(remShift - {1'b0, divisor_q});
      stepQuo = {quo_q[14:0], 1'b1};
    end
  end

  // Clamp the quotient and build the history as it will look after this
  // measurement. An empty history is filled with the first value so the
  // first estimate is the measurement itself.
  always_comb begin
    if (quo_q < 16'(MIN_BPM))      clampQ = BW'(MIN_BPM);
    else if (quo_q > 16'(MAX_BPM)) clampQ = BW'(MAX_BPM);
    else                           clampQ = quo_q[BW-1:0];
    newHist[0] = clampQ;
    for (int i = 1; i < 4; i++) newHist[i] = histValid_q ? hist_q[i-1] : clampQ;
    histSum = '0;
    for (int i = 0; i < 4; i++) histSum = histSum + SW'(newHist[i]);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler_q;
    msCount_d   = msCount_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    divisor_d   = divisor_q;
    bitCnt_d    = bitCnt_q;
    hist_d      = hist_q;
    histValid_d = histValid_q;
    bpm_d       = bpm_q;
    valid_d     = valid_q;
    update_d    = 1'b0;
    case (state_q)
      IDLE: begin
        prescaler_d = '0;
        msCount_d   = '0;
        if (beatEdge) state_d = MEASURE;
      end
      MEASURE: begin
        prescaler_d = tickPre;
        msCount_d   = tickMs;
        if (msCount_q == TO_MS) begin
          // Silence: drop the estimate quietly and wait for a new reference.
          bpm_d       = '0;
          valid_d     = 1'b0;
          histValid_d = 1'b0;
          for (int i = 0; i < 4; i++) hist_d[i] = '0;
          prescaler_d = '0;
          msCount_d   = '0;
          state_d     = IDLE;
        end else if (beatEdge && msCount_q >= MIN_INT) begin
          // Too-short intervals are glitches and keep the counter running;
          // anything else restarts it, too-long ones just become a new reference.
          prescaler_d = '0;
          msCount_d   = '0;
          if (msCount_q <= MAX_INT) begin
            divisor_d = 16'(msCount_q);
            rem_d     = '0;
            quo_d     = DIVIDEND;
            bitCnt_d  = '0;
            state_d   = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        prescaler_d = tickPre;
        msCount_d   = tickMs;
        rem_d       = stepRem;
        quo_d       = stepQuo;
        bitCnt_d    = bitCnt_q + 1'b1;
        if (bitCnt_q == 4'd15) state_d = UPDATE;
      end
      UPDATE: begin
        prescaler_d = tickPre;
        msCount_d   = tickMs;
        hist_d      = newHist;
        histValid_d = 1'b1;
        bpm_d       = BW'(histSum >> 2);
        valid_d     = 1'b1;
        update_d    = 1'b1;
        state_d     = MEASURE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beatPrev_q  <= 1'b0;
      prescaler_q <= '0;
      msCount_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      bitCnt_q    <= '0;
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      histValid_q <= 1'b0;
      bpm_q       <= '0;
      valid_q     <= 1'b0;
      update_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beatPrev_q  <= beat_in;
      prescaler_q <= prescaler_d;
      msCount_q   <= msCount_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      divisor_q   <= divisor_d;
      bitCnt_q    <= bitCnt_d;
      hist_q      <= hist_d;
      histValid_q <= histValid_d;
      bpm_q       <= bpm_d;
      valid_q     <= valid_d;
      update_q    <= update_d;
    end
  end

  assign BPM_estimate = bpm_q;
  assign bpm_valid    = valid_q;
  assign bpm_update   = update_q;

endmodule

// File: tb/tb_bpm_estimator.sv
// -----------------------------------------------------------------------------
// tb_bpm_estimator
//   Directed beat sequences with hand-computed BPM results. The stimulus
//   process pushes each expected update (value and arrival cycle) into a
//   queue; a monitor pops and compares whenever bpm_update fires.
// -----------------------------------------------------------------------------
module tb_bpm_estimator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       beat_in = 1'b0;
  logic [7:0] BPM_estimate;
  logic       bpm_valid;
  logic       bpm_update;

  bpm_estimator #(
    .CLK_FREQ_HZ(1000),
    .MIN_BPM    (40),
    .MAX_BPM    (200),
    .TIMEOUT_MS (3000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .beat_in     (beat_in),
    .BPM_estimate(BPM_estimate),
    .bpm_valid   (bpm_valid),
    .bpm_update  (bpm_update)
  );

  always #5 clk = ~clk;

  // Posedge counter; read at negedges it equals the number of edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int bpm;
    int cyc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   lastDrive = 0;

  // Monitor: every update strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bpm_update) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_update: got bpm=%0d at cyc=%0d, required no update",
                 BPM_estimate, cyc);
      end else begin
        e = expQ.pop_front();
        checks++;
        if (BPM_estimate !== 8'(e.bpm)) begin
          failures++;
          $display("[TB] FAIL update_bpm: got %0d, required %0d", BPM_estimate, e.bpm);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("[TB] FAIL update_latency: got cyc=%0d, required cyc=%0d", cyc, e.cyc);
        end
        checks++;
        if (bpm_valid !== 1'b1) begin
          failures++;
          $display("[TB] FAIL update_valid: got %0b, required 1", bpm_valid);
        end
      end
    end
  end

  // Drive a beat 'interval' cycles after the previous one and hold it high
  // for 'hold' cycles. Edge lands on the next posedge; result 17 clocks later.
  task automatic applyStimulus(input int interval, input int hold,
                               input bit expUpd, input int expBpm);
    exp_t e;
    while (cyc < lastDrive + interval) @(negedge clk);
    beat_in   = 1'b1;
    lastDrive = cyc;
    if (expUpd) begin
      e.bpm = expBpm;
      e.cyc = cyc + 18;
      expQ.push_back(e);
    end
    repeat (hold) @(negedge clk);
    beat_in = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int expBpm, input bit expValid);
    checks++;
    if (BPM_estimate !== 8'(expBpm)) begin
      failures++;
      $display("[TB] FAIL %s_bpm: got %0d, required %0d", name, BPM_estimate, expBpm);
    end
    checks++;
    if (bpm_valid !== expValid) begin
      failures++;
      $display("[TB] FAIL %s_valid: got %0b, required %0b", name, bpm_valid, expValid);
    end
    checks++;
    if (bpm_update !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_update: got %0b, required 0", name, bpm_update);
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset", 0, 1'b0);
    reset = 1'b0;
    lastDrive = cyc;

    // Basic tempo and smoothing: 500 -> 120, then 400-cycle intervals.
    applyStimulus(5,   1, 1'b0, 0);
    applyStimulus(500, 1, 1'b1, 120);
    applyStimulus(400, 1, 1'b1, 127);
    applyStimulus(400, 1, 1'b1, 135);

    // Silence: still valid one cycle before the timeout lands, cleared after.
    waitUntil(lastDrive + 3001);
    checkOutput("pre_timeout", 135, 1'b1);
    waitUntil(lastDrive + 3002);
    checkOutput("timeout", 0, 1'b0);

    // Refill after timeout, then a glitch 100 cycles after an accepted beat.
    applyStimulus(3020, 1, 1'b0, 0);
    applyStimulus(500,  1, 1'b1, 120);
    applyStimulus(100,  1, 1'b0, 0);
    applyStimulus(400,  1, 1'b1, 120);

    // Out-of-range interval is discarded and becomes the new reference.
    applyStimulus(2000, 1, 1'b0, 0);
    applyStimulus(500,  1, 1'b1, 120);
    applyStimulus(400,  1, 1'b1, 127);
    repeat (30) @(negedge clk);

    // Interval boundaries from a fresh history.
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset2", 0, 1'b0);
    reset = 1'b0;
    lastDrive = cyc;
    applyStimulus(20,   1, 1'b0, 0);
    applyStimulus(301,  1, 1'b1, 200);
    applyStimulus(1501, 1, 1'b1, 160);
    applyStimulus(300,  1, 1'b0, 0);
    applyStimulus(1202, 1, 1'b0, 0);
    applyStimulus(1501, 1, 1'b1, 120);
    repeat (30) @(negedge clk);
    checkOutput("boundary_hold", 120, 1'b1);

    // Reset while the divider is busy: result dropped, no strobe.
    applyStimulus(500, 1, 1'b0, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_divide", 0, 1'b0);
    reset = 1'b0;
    lastDrive = cyc;
    repeat (30) @(negedge clk);
    checkOutput("after_reset_divide", 0, 1'b0);

    // Long high levels still count as single edges.
    applyStimulus(10,  50, 1'b0, 0);
    applyStimulus(500, 50, 1'b1, 120);
    repeat (40) @(negedge clk);
    checkOutput("held_beat", 120, 1'b1);

    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_updates: got %0d outstanding, required 0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
